// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings and payload types for the ID/EX issue stage.
//   - ALU control codes, opcode and funct constants
//   - decoder result struct and ID/EX payload struct, plus the bubble value
//   - sign-extension helper for 16-bit immediates
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned CTL_W   = 3;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned IMM_W   = 16;

    typedef enum logic [CTL_W-1:0] {
        CTL_AND = 3'b000,
        CTL_OR  = 3'b001,
        CTL_ADD = 3'b010,
        CTL_SRL = 3'b011,
        CTL_SUB = 3'b110,
        CTL_SLT = 3'b111
    } ctl_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;
    localparam logic [OP_W-1:0] FN_SRL = 6'b000010;

    // Decoder result: valid=0 with illegal=0 means a plain bubble.
    typedef struct packed {
        ctl_e               ctl;
        logic [SHAMT_W-1:0] shamt;
        logic               imm_sel;
        logic               rt_src;
        logic [REG_W-1:0]   dest;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               illegal;
        logic               valid;
    } dec_t;

    // ID/EX register payload.
    typedef struct packed {
        ctl_e               ctl;
        logic [SHAMT_W-1:0] shamt;
        logic [DATA_W-1:0]  data_a;
        logic [DATA_W-1:0]  data_b;
        logic [DATA_W-1:0]  store_data;
        logic [REG_W-1:0]   dest_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               illegal;
    } ex_t;

    localparam ex_t EX_BUBBLE = ex_t'('0);

    function automatic logic [DATA_W-1:0] sext16(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: combinational instruction decoder.
//   instr_i : 32-bit instruction word
//   dec_o   : ALU control, shamt, immediate select, rt-is-source,
//             destination register, control bits, illegal flag, valid flag
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] instr_i,
    output dec_t              dec_o
);

    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    always_comb begin
        dec_o = dec_t'('0);
        if (instr_i != '0) begin
            dec_o.valid = 1'b1;
            unique case (opcode)
                OP_RTYPE: begin
                    dec_o.rt_src    = 1'b1;
                    dec_o.dest      = instr_i[15:11];
                    dec_o.reg_write = 1'b1;
                    unique case (funct)
                        FN_ADD:  dec_o.ctl = CTL_ADD;
                        FN_SUB:  dec_o.ctl = CTL_SUB;
                        FN_AND:  dec_o.ctl = CTL_AND;
                        FN_OR:   dec_o.ctl = CTL_OR;
                        FN_SLT:  dec_o.ctl = CTL_SLT;
                        FN_SRL: begin
                            dec_o.ctl   = CTL_SRL;
                            dec_o.shamt = instr_i[10:6];
                        end
                        default: dec_o.illegal = 1'b1;
                    endcase
                end
                OP_ADDIU, OP_LW: begin
                    dec_o.ctl       = CTL_ADD;
                    dec_o.imm_sel   = 1'b1;
                    dec_o.dest      = instr_i[20:16];
                    dec_o.reg_write = 1'b1;
                    dec_o.mem_read  = (opcode == OP_LW);
                end
                OP_SW: begin
                    dec_o.ctl       = CTL_ADD;
                    dec_o.imm_sel   = 1'b1;
                    dec_o.rt_src    = 1'b1;
                    dec_o.mem_write = 1'b1;
                end
                OP_BEQ: begin
                    dec_o.ctl    = CTL_SUB;
                    dec_o.rt_src = 1'b1;
                end
                default: dec_o.illegal = 1'b1;
            endcase
            // An illegal decode carries nothing but the flag itself.
            if (dec_o.illegal) begin
                dec_o         = dec_t'('0);
                dec_o.illegal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: ID/EX stage. Decodes, forwards operands, detects hazards and
// registers the EX-stage payload.
//   clk, rst             : clock, asynchronous active-high reset
//   InValid, Instr       : IF/ID instruction
//   RsData, RtData       : register-file read data
//   Flush                : squash the instruction being issued
//   ExMem*, MemWb*       : writeback candidates for forwarding/hazards
//   Stall                : combinational hold request for PC and IF/ID
//   Ctl..Illegal         : registered EX-stage outputs
// Build option: ALU_ISSUE_FWD_EN enables EX/MEM and MEM/WB forwarding;
// without it operands come straight from the register file and any
// in-flight dependence stalls.
module alu_issue
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              InValid,
    input  logic [DATA_W-1:0] Instr,
    input  logic [DATA_W-1:0] RsData,
    input  logic [DATA_W-1:0] RtData,
    input  logic              Flush,
    input  logic              ExMemRegWrite,
    input  logic [REG_W-1:0]  ExMemRd,
    input  logic [DATA_W-1:0] ExMemData,
    input  logic              MemWbRegWrite,
    input  logic [REG_W-1:0]  MemWbRd,
    input  logic [DATA_W-1:0] MemWbData,
    output logic              Stall,
    output logic [CTL_W-1:0]  Ctl,
    output logic [SHAMT_W-1:0] Shamt,
    output logic [DATA_W-1:0] DataA,
    output logic [DATA_W-1:0] DataB,
    output logic [DATA_W-1:0] StoreData,
    output logic [REG_W-1:0]  DestReg,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              Illegal
);

    dec_t              dec;
    ex_t               ex_q;
    ex_t               ex_d;
    logic [REG_W-1:0]  rs_idx;
    logic [REG_W-1:0]  rt_idx;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              load_use;
    logic              hazard;

    assign rs_idx = Instr[25:21];
    assign rt_idx = Instr[20:16];

    alu_ctl_decode u_decode (
        .instr_i (Instr),
        .dec_o   (dec)
    );

    // The load in EX cannot supply its data yet under either build.
    assign load_use = ex_q.mem_read && (ex_q.dest_reg != '0) &&
                      ((ex_q.dest_reg == rs_idx) ||
                       (dec.rt_src && (ex_q.dest_reg == rt_idx)));

`ifdef ALU_ISSUE_FWD_EN
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_W-1:0]  idx,
        input logic [DATA_W-1:0] rf_data,
        input logic              em_we,
        input logic [REG_W-1:0]  em_rd,
        input logic [DATA_W-1:0] em_data,
        input logic              mw_we,
        input logic [REG_W-1:0]  mw_rd,
        input logic [DATA_W-1:0] mw_data
    );
        if (idx == '0)                   return '0;
        else if (em_we && em_rd == idx)  return em_data;
        else if (mw_we && mw_rd == idx)  return mw_data;
        else                             return rf_data;
    endfunction

    assign rs_val = fwd_sel(rs_idx, RsData, ExMemRegWrite, ExMemRd, ExMemData,
                            MemWbRegWrite, MemWbRd, MemWbData);
    assign rt_val = fwd_sel(rt_idx, RtData, ExMemRegWrite, ExMemRd, ExMemData,
                            MemWbRegWrite, MemWbRd, MemWbData);
    assign hazard = load_use;
`else
    logic raw_rs;
    logic raw_rt;
    logic unused_fwd;

    assign rs_val = RsData;
    assign rt_val = RtData;

    // Without forwarding, wait until producers in ID/EX or EX/MEM retire;
    // MEM/WB is covered by the write-first register file.
    assign raw_rs = (rs_idx != '0) &&
                    ((ex_q.reg_write && ex_q.dest_reg == rs_idx) ||
                     (ExMemRegWrite && ExMemRd == rs_idx));
    assign raw_rt = dec.rt_src && (rt_idx != '0) &&
                    ((ex_q.reg_write && ex_q.dest_reg == rt_idx) ||
                     (ExMemRegWrite && ExMemRd == rt_idx));
    assign hazard = load_use || raw_rs || raw_rt;

    assign unused_fwd = ^{ExMemData, MemWbRegWrite, MemWbRd, MemWbData};
`endif

    // Flush overrides any hazard.
    assign Stall = InValid && !Flush && hazard;

    // Next ID/EX payload: bubble unless a real instruction issues.
    always_comb begin
        ex_d = EX_BUBBLE;
        if (InValid && !Flush && !hazard) begin
            if (dec.illegal) begin
                ex_d.illegal = 1'b1;
            end else if (dec.valid) begin
                ex_d.ctl        = dec.ctl;
                ex_d.shamt      = dec.shamt;
                ex_d.data_a     = rs_val;
                ex_d.data_b     = dec.imm_sel ? sext16(Instr[15:0]) : rt_val;
                ex_d.store_data = dec.mem_write ? rt_val : '0;
                ex_d.dest_reg   = dec.dest;
                ex_d.reg_write  = dec.reg_write;
                ex_d.mem_read   = dec.mem_read;
                ex_d.mem_write  = dec.mem_write;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= EX_BUBBLE;
        else     ex_q <= ex_d;
    end

    assign Ctl       = ex_q.ctl;
    assign Shamt     = ex_q.shamt;
    assign DataA     = ex_q.data_a;
    assign DataB     = ex_q.data_b;
    assign StoreData = ex_q.store_data;
    assign DestReg   = ex_q.dest_reg;
    assign RegWrite  = ex_q.reg_write;
    assign MemRead   = ex_q.mem_read;
    assign MemWrite  = ex_q.mem_write;
    assign Illegal   = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed, table-driven bench for alu_issue with hand
// sequences for forwarding, load-use, flush and reset. Expectations for
// the forwarding-dependent cases follow ALU_ISSUE_FWD_EN.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        InValid;
    logic [31:0] Instr;
    logic [31:0] RsData, RtData;
    logic        Flush;
    logic        ExMemRegWrite;
    logic [4:0]  ExMemRd;
    logic [31:0] ExMemData;
    logic        MemWbRegWrite;
    logic [4:0]  MemWbRd;
    logic [31:0] MemWbData;
    logic        Stall;
    logic [2:0]  Ctl;
    logic [4:0]  Shamt;
    logic [31:0] DataA, DataB, StoreData;
    logic [4:0]  DestReg;
    logic        RegWrite, MemRead, MemWrite, Illegal;

    int errors = 0;
    int checks = 0;

    alu_issue dut (
        .clk(clk), .rst(rst), .InValid(InValid), .Instr(Instr),
        .RsData(RsData), .RtData(RtData), .Flush(Flush),
        .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemData(ExMemData),
        .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
        .Stall(Stall), .Ctl(Ctl), .Shamt(Shamt), .DataA(DataA), .DataB(DataB),
        .StoreData(StoreData), .DestReg(DestReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef logic [112:0] out_t;

    typedef struct {
        string       name;
        logic        valid;
        logic        flush;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        out_t        exp;
    } vec_t;

    vec_t tbl[15];
    localparam out_t BUB = '0;

    function automatic out_t mk(input logic [2:0] c, input logic [4:0] sh,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] sd, input logic [4:0] d,
                                input logic rw, input logic mr,
                                input logic mw, input logic il);
        return {c, sh, a, b, sd, d, rw, mr, mw, il};
    endfunction

    function automatic out_t outs();
        return {Ctl, Shamt, DataA, DataB, StoreData, DestReg,
                RegWrite, MemRead, MemWrite, Illegal};
    endfunction

    task automatic chk(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_stall(input string name, input logic exp);
        checks++;
        if (Stall !== exp) begin
            errors++;
            $display("FAIL %s stall: got %b expected %b", name, Stall, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic f, input logic [31:0] ins,
                          input logic [31:0] rs, input logic [31:0] rt);
        InValid = v; Flush = f; Instr = ins; RsData = rs; RtData = rt;
        ExMemRegWrite = 1'b0; ExMemRd = '0; ExMemData = '0;
        MemWbRegWrite = 1'b0; MemWbRd = '0; MemWbData = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{"add",      1, 0, 32'h012A4020, 32'd5, 32'd7,
                    mk(3'b010, 0, 5, 7, 0, 8, 1, 0, 0, 0)};
        tbl[1]  = '{"sub",      1, 0, 32'h018D5822, 32'd20, 32'd3,
                    mk(3'b110, 0, 20, 3, 0, 11, 1, 0, 0, 0)};
        tbl[2]  = '{"and",      1, 0, 32'h01F07024, 32'hF0F0F0F0, 32'hFF00FF00,
                    mk(3'b000, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 14, 1, 0, 0, 0)};
        tbl[3]  = '{"or",       1, 0, 32'h02538825, 32'd1, 32'd2,
                    mk(3'b001, 0, 1, 2, 0, 17, 1, 0, 0, 0)};
        tbl[4]  = '{"slt",      1, 0, 32'h02B6A02A, 32'd9, 32'd4,
                    mk(3'b111, 0, 9, 4, 0, 20, 1, 0, 0, 0)};
        tbl[5]  = '{"srl",      1, 0, 32'h00031102, 32'd0, 32'h80,
                    mk(3'b011, 4, 0, 32'h80, 0, 2, 1, 0, 0, 0)};
        tbl[6]  = '{"addiu",    1, 0, 32'h24C5FFFF, 32'd10, 32'h99,
                    mk(3'b010, 0, 10, 32'hFFFFFFFF, 0, 5, 1, 0, 0, 0)};
        tbl[7]  = '{"lw",       1, 0, 32'h8C870008, 32'h1000, 32'h99,
                    mk(3'b010, 0, 32'h1000, 8, 0, 7, 1, 1, 0, 0)};
        tbl[8]  = '{"sw",       1, 0, 32'hAD49000C, 32'h2000, 32'h55,
                    mk(3'b010, 0, 32'h2000, 32'hC, 32'h55, 0, 0, 0, 1, 0)};
        tbl[9]  = '{"beq",      1, 0, 32'h116CFFFC, 32'd50, 32'd50,
                    mk(3'b110, 0, 50, 50, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{"bad_op",   1, 0, 32'h3F000000, 32'd1, 32'd1,
                    mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[11] = '{"bad_fn",   1, 0, 32'h012A403F, 32'd1, 32'd1,
                    mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        tbl[12] = '{"zero",     1, 0, 32'h00000000, 32'd3, 32'd3, BUB};
        tbl[13] = '{"invalid",  0, 0, 32'h012A4020, 32'd5, 32'd7, BUB};
        tbl[14] = '{"flush",    1, 1, 32'h012A4020, 32'd5, 32'd7, BUB};

        // Reset state
        rst = 1'b1;
        set_in(1'b1, 1'b0, 32'h012A4020, 32'd5, 32'd7);
        #3;
        chk("reset_out", outs(), BUB);
        chk_stall("reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Table of independent decode vectors
        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].valid, tbl[i].flush, tbl[i].instr, tbl[i].rs, tbl[i].rt);
            #1;
            chk_stall(tbl[i].name, 1'b0);
            step();
            chk(tbl[i].name, outs(), tbl[i].exp);
        end

        // Forwarding priority, and $0 never forwarded
        idle();
        set_in(1'b1, 1'b0, 32'h012A4020, 32'd5, 32'd7);
        ExMemRegWrite = 1; ExMemRd = 9; ExMemData = 100;
        MemWbRegWrite = 1; MemWbRd = 9; MemWbData = 200;
        #1;
`ifdef ALU_ISSUE_FWD_EN
        chk_stall("fwd_exmem", 1'b0);
        step();
        chk("fwd_exmem", outs(), mk(3'b010, 0, 100, 7, 0, 8, 1, 0, 0, 0));
`else
        chk_stall("fwd_exmem", 1'b1);
        step();
        chk("fwd_exmem", outs(), BUB);
`endif
        ExMemRd = 0;
        #1;
        chk_stall("fwd_memwb", 1'b0);
        step();
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_memwb", outs(), mk(3'b010, 0, 200, 7, 0, 8, 1, 0, 0, 0));
`else
        chk("fwd_memwb", outs(), mk(3'b010, 0, 5, 7, 0, 8, 1, 0, 0, 0));
`endif
        Instr = 32'h000A4020; RsData = 32'h1234;
        MemWbRd = 0;
        #1;
        chk_stall("fwd_zero", 1'b0);
        step();
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_zero", outs(), mk(3'b010, 0, 0, 7, 0, 8, 1, 0, 0, 0));
`else
        chk("fwd_zero", outs(), mk(3'b010, 0, 32'h1234, 7, 0, 8, 1, 0, 0, 0));
`endif

        // Load-use: one stall cycle, then issue with MEM/WB data
        idle();
        set_in(1'b1, 1'b0, 32'h8D280004, 32'h100, 32'h0);
        #1;
        chk_stall("lu_lw", 1'b0);
        step();
        chk("lu_lw", outs(), mk(3'b010, 0, 32'h100, 4, 0, 8, 1, 1, 0, 0));
        set_in(1'b1, 1'b0, 32'h01085020, 32'h11, 32'h11);
        #1;
        chk_stall("lu_hold", 1'b1);
        step();
        chk("lu_bubble", outs(), BUB);
        MemWbRegWrite = 1; MemWbRd = 8; MemWbData = 32'h777;
        #1;
        chk_stall("lu_release", 1'b0);
        step();
`ifdef ALU_ISSUE_FWD_EN
        chk("lu_issue", outs(), mk(3'b010, 0, 32'h777, 32'h777, 0, 10, 1, 0, 0, 0));
`else
        chk("lu_issue", outs(), mk(3'b010, 0, 32'h11, 32'h11, 0, 10, 1, 0, 0, 0));
`endif

        // Flush beats load-use stall and illegal decode
        idle();
        set_in(1'b1, 1'b0, 32'h8D280004, 32'h100, 32'h0);
        step();
        set_in(1'b1, 1'b1, 32'h01085020, 32'h11, 32'h11);
        #1;
        chk_stall("flush_lu", 1'b0);
        step();
        chk("flush_lu", outs(), BUB);
        set_in(1'b1, 1'b1, 32'h3F000000, 32'h0, 32'h0);
        #1;
        chk_stall("flush_ill", 1'b0);
        step();
        chk("flush_ill", outs(), BUB);

        // Reset in mid-run clears immediately; first edge after issues
        set_in(1'b1, 1'b0, 32'h8D280004, 32'h100, 32'h0);
        step();
        set_in(1'b1, 1'b0, 32'h01085020, 32'h11, 32'h11);
        #1;
        chk_stall("pre_rst", 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst", outs(), BUB);
        chk_stall("mid_rst", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b1, 1'b0, 32'h012A4020, 32'd5, 32'd7);
        step();
        chk("post_rst", outs(), mk(3'b010, 0, 5, 7, 0, 8, 1, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
